// File: rtl/fpu_mul_pkg.sv
// Shared types and constants for the binary32 multiply sequencer.
package fpu_mul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_MUL,
        ST_NORM,
        ST_ROUND,
        ST_DONE
    } state_e;

    localparam int          MUL_CYCLES = 24;
    localparam logic [9:0]  BIAS_ADJ   = 10'h381;
    localparam int          EXP_MAX    = 255;
    localparam logic [31:0] QNAN       = 32'h7FC0_0000;

    localparam int SIGN_BIT = 31;
    localparam int EXP_HI   = 30;
    localparam int EXP_LO   = 23;
    localparam int MAN_HI   = 22;
    localparam int MAN_LO   = 0;

endpackage

// File: rtl/fp_mul_sequencer_if.sv
// Operand/result handshake bundle between issue logic, the multiplier and writeback.
interface fp_mul_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z;
    logic        overflow;
    logic        underflow;
    logic        invalid;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, z, overflow, underflow, invalid
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, z, overflow, underflow, invalid
    );
endinterface

// File: rtl/fp_mul_exp_add.sv
// Biased exponent sum (Ea+Eb-127 as 10-bit two's complement) and zero-exponent detects.
module fp_mul_exp_add
    import fpu_mul_pkg::*;
(
    input  logic [7:0] ea,
    input  logic [7:0] eb,
    output logic [9:0] exp_sum,
    output logic       a_zero,
    output logic       b_zero
);

    assign exp_sum = {2'b00, ea} + {2'b00, eb} + BIAS_ADJ;
    assign a_zero  = (ea == 8'd0);
    assign b_zero  = (eb == 8'd0);

endmodule

// File: rtl/fp_mul_sequencer.sv
// Multi-cycle binary32 multiplier: special-operand screen, 24-step shift-add, normalize, RNE.
//   state | meaning
//   IDLE  | ready for an operand pair
//   CHECK | sign/exponent sum, special-operand screen
//   MUL   | one multiplier bit per cycle into the accumulator
//   NORM  | align product, extract mantissa/guard/sticky
//   ROUND | round-to-nearest-even, overflow/underflow clamp
//   DONE  | result held until out_ready
module fp_mul_sequencer
    import fpu_mul_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    fp_mul_sequencer_if.slave bus
);

    localparam logic [4:0] CNT_LAST = 5'(MUL_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic        sign_q, sign_d;
    logic [9:0]  exp_q, exp_d;
    logic [23:0] mcand_q, mcand_d;
    logic [47:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [22:0] man_q, man_d;
    logic        guard_q, guard_d, sticky_q, sticky_d;
    logic [31:0] z_q, z_d;
    logic        ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d;

    logic [9:0]  exp_sum;
    logic        a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, special;
    logic [24:0] add_sum;
    logic        round_inc;
    logic [23:0] man_rnd;
    logic [9:0]  exp_rnd;

    fp_mul_exp_add u_exp_add (
        .ea      (a_q[EXP_HI:EXP_LO]),
        .eb      (b_q[EXP_HI:EXP_LO]),
        .exp_sum (exp_sum),
        .a_zero  (a_zero),
        .b_zero  (b_zero)
    );

    assign a_nan   = (a_q[EXP_HI:EXP_LO] == 8'hFF) && (a_q[MAN_HI:MAN_LO] != 23'd0);
    assign b_nan   = (b_q[EXP_HI:EXP_LO] == 8'hFF) && (b_q[MAN_HI:MAN_LO] != 23'd0);
    assign a_inf   = (a_q[EXP_HI:EXP_LO] == 8'hFF) && (a_q[MAN_HI:MAN_LO] == 23'd0);
    assign b_inf   = (b_q[EXP_HI:EXP_LO] == 8'hFF) && (b_q[MAN_HI:MAN_LO] == 23'd0);
    assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

    // Right-shifting product register: upper half accumulates, lower half holds the multiplier.
    assign add_sum   = {1'b0, acc_q[47:24]} + (acc_q[0] ? {1'b0, mcand_q} : 25'd0);
    assign round_inc = guard_q & (sticky_q | man_q[0]);
    assign man_rnd   = {1'b0, man_q} + {23'd0, round_inc};
    assign exp_rnd   = exp_q + {9'd0, man_rnd[23]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.in_valid) state_d = ST_CHECK;
            ST_CHECK: state_d = special ? ST_DONE : ST_MUL;
            ST_MUL:   if (cnt_q == CNT_LAST) state_d = ST_NORM;
            ST_NORM:  state_d = ST_ROUND;
            ST_ROUND: state_d = ST_DONE;
            ST_DONE:  if (bus.out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE);
        bus.out_valid = (state_q == ST_DONE);
        bus.z         = z_q;
        bus.overflow  = ovf_q;
        bus.underflow = unf_q;
        bus.invalid   = inv_q;
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        man_d    = man_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        z_d      = z_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inv_d    = inv_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d = bus.a;
                    b_d = bus.b;
                end
            end
            ST_CHECK: begin
                sign_d  = a_q[SIGN_BIT] ^ b_q[SIGN_BIT];
                exp_d   = exp_sum;
                mcand_d = {1'b1, a_q[MAN_HI:MAN_LO]};
                acc_d   = {24'd0, 1'b1, b_q[MAN_HI:MAN_LO]};
                cnt_d   = 5'd0;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                inv_d   = 1'b0;
                if (a_nan || b_nan) begin
                    z_d = QNAN;
                end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
                    z_d   = QNAN;
                    inv_d = 1'b1;
                end else if (a_inf || b_inf) begin
                    z_d = {a_q[SIGN_BIT] ^ b_q[SIGN_BIT], 8'hFF, 23'd0};
                end else if (a_zero || b_zero) begin
                    z_d = {a_q[SIGN_BIT] ^ b_q[SIGN_BIT], 31'd0};
                end
            end
            ST_MUL: begin
                acc_d = {add_sum, acc_q[23:1]};
                cnt_d = (cnt_q == CNT_LAST) ? 5'd0 : cnt_q + 5'd1;
            end
            ST_NORM: begin
                if (acc_q[47]) begin
                    man_d    = acc_q[46:24];
                    guard_d  = acc_q[23];
                    sticky_d = |acc_q[22:0];
                    exp_d    = exp_q + 10'd1;
                end else begin
                    man_d    = acc_q[45:23];
                    guard_d  = acc_q[22];
                    sticky_d = |acc_q[21:0];
                end
            end
            ST_ROUND: begin
                if ($signed(exp_rnd) >= $signed(10'(EXP_MAX))) begin
                    z_d   = {sign_q, 8'hFF, 23'd0};
                    ovf_d = 1'b1;
                end else if ($signed(exp_rnd) <= $signed(10'd0)) begin
                    z_d   = {sign_q, 31'd0};
                    unf_d = 1'b1;
                end else begin
                    z_d = {sign_q, exp_rnd[7:0], man_rnd[22:0]};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            man_q    <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            z_q      <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            man_q    <= man_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            z_q      <= z_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inv_q    <= inv_d;
        end
    end

endmodule

// File: tb/tb_fp_mul_sequencer.sv
// Directed bench for fp_mul_sequencer with an arithmetic reference model and per-cycle result compare.
module tb_fp_mul_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    fp_mul_sequencer_if bus_if ();

    fp_mul_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    logic        armed = 1'b0;
    logic [31:0] exp_z;
    logic [2:0]  exp_fl;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
        logic [2:0]  fl;    // {overflow, underflow, invalid}
        int          lat;   // edges after the accept edge until out_valid is seen
        int          hold;  // cycles of out_ready=0 while in DONE
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    // Reference: exact integer product, then RNE by remainder comparison.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] z, output logic [2:0] fl);
        int ea, eb, e, sh;
        logic s;
        bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        longint unsigned p, q, rem, half;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        fl = 3'b000;
        z  = 32'd0;
        if (a_nan || b_nan) begin
            z = 32'h7FC0_0000;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            z  = 32'h7FC0_0000;
            fl = 3'b001;
        end else if (a_inf || b_inf) begin
            z = {s, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            z = {s, 31'd0};
        end else begin
            p  = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
            e  = ea + eb - 127;
            sh = 23;
            if (p >= (64'd1 << 47)) begin
                sh = 24;
                e  = e + 1;
            end
            q    = p >> sh;
            rem  = p - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && (q & 64'd1) == 64'd1)) q = q + 1;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
            if (e >= 255) begin
                z  = {s, 8'hFF, 23'd0};
                fl = 3'b100;
            end else if (e <= 0) begin
                z  = {s, 31'd0};
                fl = 3'b010;
            end else begin
                z = {s, 8'(e), q[22:0]};
            end
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && armed && bus_if.out_valid) begin
            chk("z_vs_model", bus_if.z, exp_z);
            chk("flags_vs_model",
                {29'd0, bus_if.overflow, bus_if.underflow, bus_if.invalid},
                {29'd0, exp_fl});
        end
    end

    task automatic run_txn(input vec_t v, input int idx);
        int k;
        logic [31:0] mz;
        logic [2:0]  mfl;
        model(v.a, v.b, mz, mfl);
        chk($sformatf("model_z[%0d]", idx), mz, v.z);
        chk($sformatf("model_fl[%0d]", idx), {29'd0, mfl}, {29'd0, v.fl});
        @(negedge clk);
        k = 0;
        while (!bus_if.in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("idle_wait[%0d]", idx), {31'd0, bus_if.in_ready}, 32'd1);
        bus_if.in_valid = 1'b1;
        bus_if.a        = v.a;
        bus_if.b        = v.b;
        exp_z           = mz;
        exp_fl          = mfl;
        armed           = 1'b1;
        @(posedge clk);
        #1;
        // Busy: operands and in_valid may wander freely without effect.
        bus_if.a = $urandom;
        bus_if.b = $urandom;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
            if (!bus_if.out_valid) chk($sformatf("busy_ready[%0d]", idx), {31'd0, bus_if.in_ready}, 32'd0);
        end while (!bus_if.out_valid && k < 60);
        chk($sformatf("latency[%0d]", idx), k, v.lat);
        for (int h = 0; h < v.hold; h++) begin
            bus_if.a = $urandom;
            bus_if.b = $urandom;
            chk($sformatf("hold_ready[%0d]", idx), {31'd0, bus_if.in_ready}, 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("hold_valid[%0d]", idx), {31'd0, bus_if.out_valid}, 32'd1);
        end
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk($sformatf("post_hs_valid[%0d]", idx), {31'd0, bus_if.out_valid}, 32'd0);
        chk($sformatf("post_hs_ready[%0d]", idx), {31'd0, bus_if.in_ready}, 32'd1);
        armed            = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  {31'd0, bus_if.in_ready},  32'd1);
        chk({tag, "_out_valid"}, {31'd0, bus_if.out_valid}, 32'd0);
        chk({tag, "_z"},         bus_if.z,                  32'd0);
        chk({tag, "_flags"},
            {29'd0, bus_if.overflow, bus_if.underflow, bus_if.invalid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.a         = 32'd0;
        bus_if.b         = 32'd0;
        bus_if.out_ready = 1'b0;

        // Normal results become visible 27 edges after the accept edge (cycle T+28);
        // special operands after 1 edge (cycle T+2).
        vecs = '{
            '{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3'b000, 27, 0},
            '{32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 3'b000, 27, 5},
            '{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 3'b000, 27, 0},
            '{32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 3'b100, 27, 0},
            '{32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 3'b010, 27, 0},
            '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b001,  1, 0},
            '{32'hC000_0000, 32'h0000_0000, 32'h8000_0000, 3'b000,  1, 0},
            '{32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 3'b000,  1, 0},
            '{32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 3'b000,  1, 2},
            '{32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 3'b000, 27, 0},
            '{32'hBF80_0000, 32'h3F80_0000, 32'hBF80_0000, 3'b000, 27, 0}
        };

        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_txn(vecs[i], i);

        // Abort during the multiply, then confirm the block recovers cleanly.
        @(negedge clk);
        bus_if.in_valid = 1'b1;
        bus_if.a        = 32'h4000_0000;
        bus_if.b        = 32'h4040_0000;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(vecs[0], 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_mul_sequencer.md
# fp_mul_sequencer

Multi-cycle controller for the single-precision multiplier path of the FPU. It accepts one operand pair per transaction over a valid/ready handshake and screens special operands. It then sequences the biased exponent sum, a 24-cycle shift-add mantissa multiply, normalization and round-to-nearest-even, and returns a packed IEEE-754 result with exception flags. It sits between the FPU issue logic and the writeback mux.

## Interface
- MUL_CYCLES, 24: mantissa iterations, one multiplier bit per cycle; fixed for binary32.
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block idle, can accept.
- A, B  in  32  IEEE-754 binary32 operands.
- out_valid  out  1  result valid, held until taken.
- out_ready  in  1  consumer accepts result.
- Z  out  32  packed product.
- overflow, underflow, invalid  out  1 each  exception flags, valid with out_valid.

## Operation
- States: IDLE, CHECK, MUL, NORM, ROUND, DONE.
- IDLE: in_ready=1. in_valid&in_ready latches A, B and goes to CHECK.
- CHECK:
  - Sign = A[31]^B[31].
  - Exponent sum is Ea+Eb+10'h381, i.e. Ea+Eb-127 in 10-bit two's complement.
  - E=0 operands are treated as zero (denormals-are-zero).
  - Any NaN gives Z=0x7FC00000, and ±inf × zero also sets invalid. Either case goes to DONE.
  - inf × nonzero gives signed inf, no flag. Zero × finite gives signed zero, no flag. Both go to DONE.
  - Otherwise load 24-bit mantissas {1,M} and go to MUL.
- MUL: 48-bit accumulator with shift-add on the LSB of the multiplier; 5-bit counter runs 0..23. Counter terminal value goes to NORM.
- NORM: if P[47]=1, shift right one and add 1 to exponent. Mantissa is 23 bits below the leading one. Guard is the next bit; sticky is the OR of the rest.
- ROUND (RNE):
  - Increment mantissa when guard & (sticky | lsb).
  - A mantissa carry-out adds 1 to exponent and zeroes the mantissa.
  - Signed exponent ≥255 gives signed inf and overflow.
  - Exponent ≤0 gives signed zero and underflow (flush, no denormal output).
  - Go to DONE.
- DONE: out_valid=1, Z and flags stable. out_valid&out_ready returns to IDLE; no same-cycle re-accept.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, Z=0, all flags=0, counter=0, accumulator=0.
- Accept edge T. CHECK occupies cycle T+1.
- Special case: out_valid is high from T+2.
- Normal case: MUL runs T+2..T+25, NORM T+26, ROUND T+27, out_valid high from T+28. Latency is 28 cycles.
- in_ready=0 in every state except IDLE. in_valid is ignored while busy; A and B may change freely after acceptance.
- Back-pressure: DONE holds indefinitely while out_ready=0, and Z and flags must not change.
- Next accept is at the earliest one cycle after the output handshake. Throughput is 1 per 29 cycles with out_ready tied high.
- Reset asserted in any state aborts immediately to reset values. A pending result is discarded.
- Flags are mutually exclusive per transaction.

## Structure
- Shared package fpu_mul_pkg holds:
  - state enum;
  - BIAS_ADJ=10'h381, EXP_MAX=255;
  - QNAN=32'h7FC00000;
  - field-slice constants for sign, exponent and mantissa.
- One sub-module, fp_mul_exp_add: combinational 10-bit biased exponent sum plus zero-exponent detects, instantiated in CHECK.
- The sequencer owns the FSM, counter, accumulator, normalize and round logic.

## Test plan
- 0x40000000 × 0x40400000 (2×3) → Z=0x40C00000, out_valid at T+28, no flags.
- 0x3FC00000 × 0x3FC00000 (1.5²) → 0x40100000 through the NORM right-shift path. 0x3F800001 × 0x3F800001 → 0x3F800002 (RNE, sticky set).
- 0x7F000000 × 0x7F000000 → 0x7F800000 with overflow. 0x00800000 × 0x00800000 → 0x00000000 with underflow.
- 0x7F800000 × 0x00000000 → 0x7FC00000 with invalid at T+2. 0xC0000000 × 0x00000000 → 0x80000000 at T+2, no flag.
- Hold out_ready=0 for 5 cycles in DONE → Z and flags stable, in_ready=0, in_valid ignored. Handshake completes, then in_ready=1 the next cycle.
- Assert RST during MUL cycle 10 → all outputs at reset values immediately. The next transaction (2×3) completes correctly.
